// File: rtl/coax_pkg.sv
// Shared definitions for the SPI command sequencer that fronts the buffered coax receiver.
package coax_pkg;

   localparam logic [7:0] CMD_READ_STATUS = 8'h01;
   localparam logic [7:0] CMD_RX_RESET    = 8'h02;
   localparam logic [7:0] CMD_READ_RX     = 8'h04;

   localparam logic [7:0] EMPTY_MARKER = 8'h80;

   localparam int STATUS_ACTIVE_BIT = 0;
   localparam int STATUS_ERROR_BIT  = 1;
   localparam int STATUS_EMPTY_BIT  = 2;

   typedef enum logic [2:0] {
      IDLE,
      COMMAND,
      STATUS,
      RESET_PULSE,
      READ_HI,
      READ_LO,
      DISCARD
   } state_t;

   function automatic logic [7:0] packStatus(input logic [2:0] version,
                                             input logic       empty,
                                             input logic       error,
                                             input logic       active);
      logic [7:0] b;
      b                    = 8'h00;
      b[7:5]               = version;
      b[STATUS_EMPTY_BIT]  = empty;
      b[STATUS_ERROR_BIT]  = error;
      b[STATUS_ACTIVE_BIT] = active;
      return b;
   endfunction

endpackage

// File: rtl/spi_rx_controller.sv
// Decodes the first SPI byte of a transaction as a command and answers with receiver
// status, a timed receiver reset, or a stream of FIFO words sent as high/low byte pairs.
module spi_rx_controller #(
   parameter int unsigned RX_RESET_CYCLES = 4,
   parameter logic [2:0]  STATUS_VERSION  = 3'b001
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_cs,
   input  logic [7:0] spi_rx_data,
   input  logic       spi_rx_strobe,
   output logic [7:0] spi_tx_data,
   output logic       spi_tx_strobe,
   output logic       rx_reset,
   input  logic       rx_active,
   input  logic       rx_error,
   input  logic [9:0] rx_data,
   output logic       rx_read_strobe,
   input  logic       rx_empty
);
   import coax_pkg::*;

   localparam logic [3:0] PULSE_LAST = 4'(RX_RESET_CYCLES - 1);

   state_t     r_state;
   state_t     w_nextState;
   logic [7:0] r_txData;
   logic [7:0] w_txData;
   logic       r_txStrobe;
   logic       w_txStrobe;
   logic       r_rxReset;
   logic       w_rxReset;
   logic       r_readStrobe;
   logic       w_readStrobe;
   logic [9:0] r_word;
   logic [9:0] w_word;
   logic [3:0] r_count;
   logic [3:0] w_count;
   logic       w_hiLoad;
   logic [7:0] w_status;

   assign w_status = packStatus(STATUS_VERSION, rx_empty, rx_error, rx_active);

   // Every response is computed here and registered, so it appears one cycle after its strobe.
   always_comb begin
      w_nextState  = r_state;
      w_txData     = r_txData;
      w_txStrobe   = 1'b0;
      w_rxReset    = 1'b0;
      w_readStrobe = 1'b0;
      w_word       = r_word;
      w_count      = r_count;
      w_hiLoad     = 1'b0;

      case (r_state)
         IDLE: begin
            if (!spi_cs) begin
               w_nextState = COMMAND;
            end
         end

         COMMAND: begin
            if (spi_cs) begin
               w_nextState = IDLE;
            end else if (spi_rx_strobe) begin
               w_txStrobe = 1'b1;
               case (spi_rx_data)
                  CMD_READ_STATUS: begin
                     w_txData    = w_status;
                     w_nextState = STATUS;
                  end
                  CMD_RX_RESET: begin
                     w_txData    = 8'h00;
                     w_rxReset   = 1'b1;
                     w_count     = PULSE_LAST;
                     w_nextState = RESET_PULSE;
                  end
                  CMD_READ_RX: begin
                     w_hiLoad = 1'b1;
                  end
                  default: begin
                     w_txData    = 8'h00;
                     w_nextState = DISCARD;
                  end
               endcase
            end
         end

         STATUS: begin
            if (spi_cs) begin
               w_nextState = IDLE;
            end else if (spi_rx_strobe) begin
               w_txStrobe = 1'b1;
               w_txData   = w_status;
            end
         end

         // The pulse runs to completion regardless of chip select; only bytes need cs low.
         RESET_PULSE: begin
            w_rxReset = 1'b1;
            if (r_count == 4'd0) begin
               w_rxReset   = 1'b0;
               w_nextState = spi_cs ? IDLE : DISCARD;
            end else begin
               w_count = r_count - 4'd1;
            end
            if (!spi_cs && spi_rx_strobe) begin
               w_txStrobe = 1'b1;
               w_txData   = 8'h00;
            end
         end

         READ_HI: begin
            if (spi_cs) begin
               w_nextState = IDLE;
            end else if (spi_rx_strobe) begin
               w_hiLoad = 1'b1;
            end
         end

         READ_LO: begin
            if (spi_cs) begin
               w_nextState = IDLE;
            end else if (spi_rx_strobe) begin
               w_txStrobe  = 1'b1;
               w_txData    = r_word[7:0];
               w_nextState = READ_HI;
            end
         end

         DISCARD: begin
            if (spi_cs) begin
               w_nextState = IDLE;
            end else if (spi_rx_strobe) begin
               w_txStrobe = 1'b1;
               w_txData   = 8'h00;
            end
         end

         default: begin
            w_nextState = IDLE;
         end
      endcase

      // High-byte slot is shared by the READ_RX command byte and every later even byte.
      if (w_hiLoad) begin
         w_txStrobe  = 1'b1;
         w_nextState = READ_LO;
         if (!rx_empty) begin
            w_word       = rx_data;
            w_txData     = {6'b000000, rx_data[9:8]};
            w_readStrobe = 1'b1;
         end else begin
            w_word   = 10'h000;
            w_txData = EMPTY_MARKER;
         end
      end
   end

   // State and registered outputs; reset also cuts short any reset pulse in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_txData     <= 8'h00;
         r_txStrobe   <= 1'b0;
         r_rxReset    <= 1'b0;
         r_readStrobe <= 1'b0;
         r_word       <= 10'h000;
         r_count      <= 4'd0;
      end else begin
         r_state      <= w_nextState;
         r_txData     <= w_txData;
         r_txStrobe   <= w_txStrobe;
         r_rxReset    <= w_rxReset;
         r_readStrobe <= w_readStrobe;
         r_word       <= w_word;
         r_count      <= w_count;
      end
   end

   assign spi_tx_data    = r_txData;
   assign spi_tx_strobe  = r_txStrobe;
   assign rx_reset       = r_rxReset;
   assign rx_read_strobe = r_readStrobe;

endmodule
